seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (minimum 4).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have parameter MUL_EN, default 1; 1 = MUL opcode implemented, 0 = MUL decoded as NOP.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, operation request.
REQ-007 SHALL have port in_ready, output, 1, block can accept a request this cycle.
REQ-008 SHALL have port alu_operation, input, 4, opcode.
REQ-009 SHALL have ports op1 and op2, input, WIDTH each, operands.
REQ-010 SHALL have port shamt, input, SHW, shift amount.
REQ-011 SHALL have port out_valid, output, 1, one-cycle pulse marking valid result.
REQ-012 SHALL have port result, output, WIDTH, registered result.
REQ-013 SHALL have port result_hi, output, WIDTH, upper product half (MUL only, else 0).
REQ-014 SHALL have port flag, output, 3, registered condition codes: [0]=Z, [1]=N, [2]=C.

Function
REQ-015 SHALL accept a request on a cycle where in_valid and in_ready are both 1; no other cycle accepts.
REQ-016 SHALL have FSM states IDLE, MUL_RUN; in_ready = 1 only in IDLE.
REQ-017 SHALL, for a non-MUL request accepted in cycle n, drive result, flag and out_valid=1 in cycle n+1, staying in IDLE (back-to-back issue allowed).
REQ-018 SHALL implement opcodes: 0100 NOT ~op2; 0101 INC op2+1; 0110 DEC op2-1; 0111 MOV op1; 1000 ADD op1+op2; 1001 SUB op2-op1; 1010 AND; 1011 OR; 1100 SHL op2<<shamt; 1101 SHR op2>>shamt (logical); 1110 MUL op1*op2 unsigned.
REQ-019 SHALL treat 0001 OUT as result=op1 and 0010 IN as result=op2, with flags unchanged.
REQ-020 SHALL treat 0000, 0011 NOP, 1111, and MUL with MUL_EN=0 as NOP: out_valid pulses, result and flags hold.
REQ-021 SHALL update Z = (result==0) and N = result[WIDTH-1] for NOT, INC, DEC, ADD, SUB, AND, OR, SHL, SHR and MUL; MOV, IN, OUT and NOP leave all flags unchanged.
REQ-022 SHALL set C for ADD/INC to the carry-out; for SUB/DEC to the borrow (op2<op1, or op2==0 for DEC); for SHL to op2[WIDTH-shamt]; for SHR to op2[shamt-1].
REQ-023 SHALL, for SHL/SHR with shamt=0, produce result=op2 and leave C unchanged; shamt>=WIDTH SHALL produce result 0 with C = last bit shifted out.
REQ-024 SHALL leave C unchanged for NOT, AND and OR.
REQ-025 SHALL, for MUL accepted in cycle n, enter MUL_RUN and iterate shift-add one bit per cycle for WIDTH cycles; result/result_hi/out_valid in cycle n+WIDTH+1, then return to IDLE.
REQ-026 SHALL set MUL flags from the full 2*WIDTH product: Z = product==0, N = result_hi[WIDTH-1], C = (result_hi!=0).
REQ-027 SHALL hold result, result_hi and flag stable between out_valid pulses; result_hi SHALL be 0 after any non-MUL operation.
REQ-028 SHALL ignore in_valid during MUL_RUN; the requester SHALL keep the request pending.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, set state IDLE, counter 0, result 0, result_hi 0, flag 3'b000, out_valid 0.
REQ-030 SHALL, when rst is asserted during MUL_RUN, abort the multiply with no out_valid pulse.
REQ-031 SHALL assert in_ready on the first cycle after rst deasserts.

Structure
REQ-032 SHALL place opcode constants, flag bit indices (Z=0, N=1, C=2) and the FSM state type in shared package alu_pkg.
REQ-033 SHALL implement the iterative multiplier as sub-module alu_mul_iter (start, done, WIDTH-parametrised); all other logic stays in seq_alu.

Verification
REQ-034 SHALL check that ADD op1=16'hFFFF, op2=16'h0001 gives result 0 and flag=3'b101 one cycle after acceptance.
REQ-035 SHALL check that SUB op1=5, op2=3 gives result 16'hFFFE and flag=3'b110.
REQ-036 SHALL check that SHL op2=16'h8001 with shamt=1 gives result 16'h0002 and C=1, and that a following SHR with shamt=0 leaves C=1 and result=op2.
REQ-037 SHALL check that MUL op1=16'h1234, op2=16'h0100 gives in_ready=0 for 16 cycles, then result=16'h3400, result_hi=16'h0012, C=1 on cycle n+17.
REQ-038 SHALL check that rst during MUL_RUN cycle 5 gives no out_valid, all outputs 0, and in_ready=1 on the next cycle.
REQ-039 SHALL check that back-to-back INC then MOV issued on consecutive cycles gives two consecutive out_valid pulses, with MOV leaving the INC flags intact.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP0  = 4'b0000,
    OP_OUT   = 4'b0001,
    OP_IN    = 4'b0010,
    OP_NOP   = 4'b0011,
    OP_NOT   = 4'b0100,
    OP_INC   = 4'b0101,
    OP_DEC   = 4'b0110,
    OP_MOV   = 4'b0111,
    OP_ADD   = 4'b1000,
    OP_SUB   = 4'b1001,
    OP_AND   = 4'b1010,
    OP_OR    = 4'b1011,
    OP_SHL   = 4'b1100,
    OP_SHR   = 4'b1101,
    OP_MUL   = 4'b1110,
    OP_NOP15 = 4'b1111
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   step_sum;

  // One shift-add step; product is the partial product after this cycle's step,
  // which equals the full product during the final (done) cycle.
  always_comb begin
    step_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    product  = {step_sum, lo[WIDTH-1:1]};
    done     = busy && (cnt == CW'(WIDTH - 1));
  end

  // Operand load on start, then iterate until WIDTH steps have been taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      mcand <= a;
      hi    <= '0;
      lo    <= b;
    end else if (busy) begin
      {hi, lo} <= product;
      cnt      <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops with registered result/flags, iterative MUL.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SHW    = $clog2(WIDTH),
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_operation,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [2:0]       flag
);

  localparam bit MUL_ON = (MUL_EN != 0);

  state_e               state;
  state_e               state_nxt;
  alu_op_e              op;
  logic                 accept;
  logic                 is_mul;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     prod_hi;
  logic [WIDTH-1:0]     nxt_res;
  logic [2:0]           nxt_flag;
  logic                 set_zn;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       shl_ext;
  logic [WIDTH:0]       shr_ext;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (op1),
    .b       (op2),
    .done    (mul_done),
    .product (product)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: MUL parks the FSM in MUL_RUN until the multiplier finishes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_start) state_nxt = MUL_RUN;
      MUL_RUN: if (mul_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs and request handshake.
  always_comb begin
    op        = alu_op_e'(alu_operation);
    in_ready  = (state == IDLE);
    accept    = in_valid && in_ready;
    is_mul    = MUL_ON && (op == OP_MUL);
    mul_start = accept && is_mul;
    prod_hi   = product[2*WIDTH-1:WIDTH];
  end

  // Single-cycle datapath; shifts run on a one-bit-extended operand so the
  // extra bit is exactly the last bit shifted out (0 once shamt exceeds WIDTH).
  always_comb begin
    nxt_res  = result;
    nxt_flag = flag;
    set_zn   = 1'b0;
    sum      = '0;
    shl_ext  = {1'b0, op2} << shamt;
    shr_ext  = {op2, 1'b0} >> shamt;
    case (op)
      OP_OUT, OP_MOV: nxt_res = op1;
      OP_IN:          nxt_res = op2;
      OP_NOT: begin
        nxt_res = ~op2;
        set_zn  = 1'b1;
      end
      OP_INC: begin
        sum              = {1'b0, op2} + (WIDTH+1)'(1);
        nxt_res          = sum[WIDTH-1:0];
        nxt_flag[FLAG_C] = sum[WIDTH];
        set_zn           = 1'b1;
      end
      OP_DEC: begin
        nxt_res          = op2 - WIDTH'(1);
        nxt_flag[FLAG_C] = (op2 == '0);
        set_zn           = 1'b1;
      end
      OP_ADD: begin
        sum              = {1'b0, op1} + {1'b0, op2};
        nxt_res          = sum[WIDTH-1:0];
        nxt_flag[FLAG_C] = sum[WIDTH];
        set_zn           = 1'b1;
      end
      OP_SUB: begin
        nxt_res          = op2 - op1;
        nxt_flag[FLAG_C] = (op2 < op1);
        set_zn           = 1'b1;
      end
      OP_AND: begin
        nxt_res = op1 & op2;
        set_zn  = 1'b1;
      end
      OP_OR: begin
        nxt_res = op1 | op2;
        set_zn  = 1'b1;
      end
      OP_SHL: begin
        nxt_res = shl_ext[WIDTH-1:0];
        if (shamt != '0) nxt_flag[FLAG_C] = shl_ext[WIDTH];
        set_zn  = 1'b1;
      end
      OP_SHR: begin
        nxt_res = shr_ext[WIDTH:1];
        if (shamt != '0) nxt_flag[FLAG_C] = shr_ext[0];
        set_zn  = 1'b1;
      end
      default: ;
    endcase
    if (set_zn) begin
      nxt_flag[FLAG_Z] = (nxt_res == '0);
      nxt_flag[FLAG_N] = nxt_res[WIDTH-1];
    end
  end

  // Result/flag registers: single-cycle ops on acceptance, MUL on multiplier done.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      flag      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mul) begin
        result    <= nxt_res;
        result_hi <= '0;
        flag      <= nxt_flag;
        out_valid <= 1'b1;
      end else if (mul_done) begin
        result         <= product[WIDTH-1:0];
        result_hi      <= prod_hi;
        flag[FLAG_Z]   <= (product == '0);
        flag[FLAG_N]   <= prod_hi[WIDTH-1];
        flag[FLAG_C]   <= (prod_hi != '0);
        out_valid      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed literal cases plus randomized traffic
// checked every cycle against a behavioural model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_operation = 4'h0;
  logic [15:0] op1 = '0;
  logic [15:0] op2 = '0;
  logic [3:0]  shamt = '0;
  logic        out_valid;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic [2:0]  flag;

  int checks = 0;
  int failures = 0;
  bit stim_done = 1'b0;

  // Behavioural model state
  logic [15:0] m_res = '0;
  logic [15:0] m_hi = '0;
  logic [2:0]  m_flag = '0;
  logic        m_valid = 1'b0;
  int          m_busy = 0;
  logic [31:0] m_prod = '0;
  bit          m_init = 1'b0;

  seq_alu #(.WIDTH(16), .SHW(4), .MUL_EN(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_operation (alu_operation),
    .op1           (op1),
    .op2           (op2),
    .shamt         (shamt),
    .out_valid     (out_valid),
    .result        (result),
    .result_hi     (result_hi),
    .flag          (flag)
  );

  always #5 clk = ~clk;

  // Returns {flag, result} for a single-cycle op from the arithmetic definition.
  function automatic logic [18:0] model_op(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] sh,
                                           input logic [15:0] r0, input logic [2:0] f0);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned r  = r0;
    logic        c  = f0[2];
    bit          zn = 1'b0;
    logic [2:0]  f;
    case (op)
      4'd1, 4'd7: r = ua;
      4'd2:       r = ub;
      4'd4:  begin r = (~ub) & 32'hFFFF; zn = 1; end
      4'd5:  begin r = ub + 1; c = (r > 32'hFFFF); r = r & 32'hFFFF; zn = 1; end
      4'd6:  begin c = (ub == 0); r = (ub - 1) & 32'hFFFF; zn = 1; end
      4'd8:  begin r = ua + ub; c = (r > 32'hFFFF); r = r & 32'hFFFF; zn = 1; end
      4'd9:  begin c = (ub < ua); r = (ub - ua) & 32'hFFFF; zn = 1; end
      4'd10: begin r = ua & ub; zn = 1; end
      4'd11: begin r = ua | ub; zn = 1; end
      4'd12: begin
        zn = 1;
        if (sh == 0) r = ub;
        else begin r = (ub << sh) & 32'hFFFF; c = ((ub << sh) >> 16) & 1; end
      end
      4'd13: begin
        zn = 1;
        if (sh == 0) r = ub;
        else begin r = ub >> sh; c = (ub >> (sh - 1)) & 1; end
      end
      default: ;
    endcase
    f = {c, zn ? r[15] : f0[1], zn ? (r == 0) : f0[0]};
    return {f, r[15:0]};
  endfunction

  // Model advances on each rising edge from the inputs presented in that cycle.
  always @(posedge clk) begin
    m_init <= 1'b1;
    if (rst) begin
      m_res <= '0; m_hi <= '0; m_flag <= '0; m_valid <= 1'b0; m_busy <= 0;
    end else begin
      m_valid <= 1'b0;
      if (m_busy != 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_res   <= m_prod[15:0];
          m_hi    <= m_prod[31:16];
          m_flag  <= {m_prod[31:16] != 0, m_prod[31], m_prod == 0};
          m_valid <= 1'b1;
        end
      end else if (in_valid) begin
        if (alu_operation == 4'd14) begin
          m_busy <= 16;
          m_prod <= 32'(op1) * 32'(op2);
        end else begin
          {m_flag, m_res} <= model_op(alu_operation, op1, op2, shamt, m_res, m_flag);
          m_hi    <= '0;
          m_valid <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] sh);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; alu_operation = op; op1 = a; op2 = b; shamt = sh;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
  endtask

  task automatic run1(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] sh);
    issue(op, a, b, sh);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic stimulus();
    int gap;
    logic [15:0] corner [5] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF};
    logic [15:0] a, b;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_hi", 32'(result_hi), 32'h0);
    chk("rst_flag", 32'(flag), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'h1);

    run1(4'd8, 16'hFFFF, 16'h0001, 4'd0);
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("add_result", 32'(result), 32'h0);
    chk("add_flag", 32'(flag), 32'h5);

    run1(4'd9, 16'd5, 16'd3, 4'd0);
    chk("sub_result", 32'(result), 32'hFFFE);
    chk("sub_flag", 32'(flag), 32'h6);

    run1(4'd12, 16'h0000, 16'h8001, 4'd1);
    chk("shl_result", 32'(result), 32'h0002);
    chk("shl_flag", 32'(flag), 32'h4);
    run1(4'd13, 16'h0000, 16'hABCD, 4'd0);
    chk("shr0_result", 32'(result), 32'hABCD);
    chk("shr0_flag", 32'(flag), 32'h6);

    // Back-to-back INC then MOV
    @(negedge clk);
    in_valid = 1'b1; alu_operation = 4'd5; op1 = 16'h1111; op2 = 16'hFFFF;
    chk("b2b_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    chk("inc_valid", 32'(out_valid), 32'h1);
    chk("inc_result", 32'(result), 32'h0);
    chk("inc_flag", 32'(flag), 32'h5);
    alu_operation = 4'd7; op1 = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mov_valid", 32'(out_valid), 32'h1);
    chk("mov_result", 32'(result), 32'h1234);
    chk("mov_flag", 32'(flag), 32'h5);

    // MUL latency and product
    issue(4'd14, 16'h1234, 16'h0100, 4'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk("mul_busy_ready", 32'(in_ready), 32'h0);
    end
    @(negedge clk);
    chk("mul_valid", 32'(out_valid), 32'h1);
    chk("mul_result", 32'(result), 32'h3400);
    chk("mul_hi", 32'(result_hi), 32'h0012);
    chk("mul_flag", 32'(flag), 32'h4);
    chk("mul_ready", 32'(in_ready), 32'h1);

    // Reset in MUL_RUN cycle 5
    issue(4'd14, 16'h0003, 16'h0005, 4'd0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'h0);
    chk("abort_result", 32'(result), 32'h0);
    chk("abort_hi", 32'(result_hi), 32'h0);
    chk("abort_flag", 32'(flag), 32'h0);
    chk("abort_ready", 32'(in_ready), 32'h1);
    repeat (14) begin
      @(negedge clk);
      chk("abort_no_pulse", 32'(out_valid), 32'h0);
    end

    // Randomized traffic, checked by the per-cycle compare
    for (int i = 0; i < 400; i++) begin
      gap = $urandom_range(0, 3);
      if (gap > 1) begin
        @(negedge clk);
        in_valid = 1'b0;
        alu_operation = 4'($urandom); op1 = 16'($urandom); op2 = 16'($urandom);
      end
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      issue(4'($urandom_range(0, 15)), a, b, 4'($urandom));
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    stim_done = 1'b1;
  endtask

  initial begin
    fork
      begin
        while (!stim_done) begin
          @(negedge clk);
          if (m_init) begin
            chk("cmp_valid", 32'(out_valid), 32'(m_valid));
            chk("cmp_ready", 32'(in_ready), 32'(m_busy == 0));
            chk("cmp_result", 32'(result), 32'(m_res));
            chk("cmp_hi", 32'(result_hi), 32'(m_hi));
            chk("cmp_flag", 32'(flag), 32'(m_flag));
          end
        end
      end
      stimulus();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
